// File: rtl/tone_wave_gen.sv
// Square-wave tone generator feeding a 24-bit stereo codec FIFO.
// A half-period counter drives wave_level; a three-state FSM paces the sample writes.
module tone_wave_gen #(
    parameter logic [23:0] AMPLITUDE = 24'h400000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] clk_count,
    input  logic             audio_ready,
    output logic             audio_write,
    output logic [23:0]      audio_left,
    output logic [23:0]      audio_right,
    output logic             wave_level
);

    localparam logic [23:0]      NEG_AMPLITUDE = ~AMPLITUDE + 24'd1;
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP
    } wr_state_t;

    wr_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_ref;
    logic [23:0]      sample;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        sample = 24'h0;
        if (enable && clk_count != '0)
            sample = wave_level ? AMPLITUDE : NEG_AMPLITUDE;
    end

    // A change of clk_count restarts the half-period without touching the level,
    // so a retune never produces a runt pulse.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            cnt_ref    <= '0;
            wave_level <= 1'b1;
        end else if (clk_count != cnt_ref) begin
            cnt_ref <= clk_count;
            cnt     <= '0;
        end else if (clk_count == '0) begin
            cnt        <= '0;
            wave_level <= 1'b1;
        end else if (cnt == clk_count - CNT_ONE) begin
            cnt        <= '0;
            wave_level <= ~wave_level;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Latching reads the pre-edge wave_level, so a toggle on the same edge lands in the next sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            audio_write <= 1'b0;
            audio_left  <= 24'h0;
            audio_right <= 24'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (audio_ready) begin
                        audio_left  <= sample;
                        audio_right <= sample;
                        audio_write <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    audio_write <= 1'b0;
                    state       <= GAP;
                end
                GAP: begin
                    audio_write <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    audio_write <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_wave_gen.sv
// Self-checking bench for tone_wave_gen: closed-form tone model plus a write-slot scoreboard,
// compared every cycle, with directed literal checks that pin the model.
module tb_tone_wave_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] clk_count;
    logic        audio_ready;
    logic        audio_write;
    logic [23:0] audio_left;
    logic [23:0] audio_right;
    logic        wave_level;

    int n_tests = 0;
    int n_fail  = 0;

    tone_wave_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clk_count   (clk_count),
        .audio_ready (audio_ready),
        .audio_write (audio_write),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .wave_level  (wave_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [23:0] exp_sample(input logic en, input logic [31:0] n, input logic lvl);
        if (!en || n == 0) return 24'h0;
        return lvl ? 24'h400000 : 24'hC00000;
    endfunction

    // Model: level is derived from the edge count since the last clk_count change;
    // a write is accepted at most every third edge while ready is high.
    longint      t = 0;
    longint      t0 = 0;
    longint      acc_edge = -100;
    longint      next_ok = 0;
    logic [31:0] n_ref = 0;
    logic        lvl0 = 1'b1;
    logic        m_level = 1'b1;
    logic [23:0] m_data = 24'h0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_ref    = 0;
            lvl0     = 1'b1;
            t0       = t;
            m_level  = 1'b1;
            m_data   = 24'h0;
            acc_edge = -100;
            next_ok  = 0;
        end else begin
            t++;
            if (audio_ready && t >= next_ok) begin
                m_data   = exp_sample(enable, clk_count, m_level);
                acc_edge = t;
                next_ok  = t + 3;
            end
            if (clk_count != n_ref) begin
                n_ref = clk_count;
                t0    = t;
                lvl0  = m_level;
            end else if (n_ref == 0) begin
                m_level = 1'b1;
            end else begin
                m_level = lvl0 ^ ((((t - t0) / longint'(n_ref)) % 2) != 0);
            end
        end
    end

    always @(negedge clk) begin
        check("model_wave_level", {31'h0, wave_level}, {31'h0, m_level});
        check("model_audio_write", {31'h0, audio_write}, {31'h0, (reset_n && acc_edge == t)});
        check("model_audio_left", {8'h0, audio_left}, {8'h0, m_data});
        check("model_audio_right", {8'h0, audio_right}, {8'h0, m_data});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_write(input string name, input int budget);
        int k;
        k = 0;
        while (!audio_write && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_seen"}, {31'h0, audio_write}, 32'h1);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        clk_count   = 32'd4;
        audio_ready = 1'b1;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enable      = 1'($urandom_range(0, 1));
            audio_ready = 1'($urandom_range(0, 1));
            clk_count   = $urandom;
        end
        check("rst_write", {31'h0, audio_write}, 32'h0);
        check("rst_left", {8'h0, audio_left}, 32'h0);
        check("rst_right", {8'h0, audio_right}, 32'h0);
        check("rst_level", {31'h0, wave_level}, 32'h1);

        // Tone at clk_count=4, no ready: toggles 4 edges after each half-period start.
        enable      = 1'b1;
        clk_count   = 32'd4;
        audio_ready = 1'b0;
        reset_n     = 1'b1;
        tick(4);
        check("tone_before_first_toggle", {31'h0, wave_level}, 32'h1);
        check("tone_no_write", {31'h0, audio_write}, 32'h0);
        tick(1);
        check("tone_first_toggle", {31'h0, wave_level}, 32'h0);
        tick(4);
        check("tone_second_toggle", {31'h0, wave_level}, 32'h1);

        // Ready held high: writes every third edge, data follows pre-edge level.
        audio_ready = 1'b1;
        tick(1);
        check("wr1_strobe", {31'h0, audio_write}, 32'h1);
        check("wr1_left", {8'h0, audio_left}, 32'h400000);
        check("wr1_right", {8'h0, audio_right}, 32'h400000);
        tick(1);
        check("wr1_strobe_drop", {31'h0, audio_write}, 32'h0);
        check("wr1_hold", {8'h0, audio_left}, 32'h400000);
        tick(1);
        check("gap_no_write", {31'h0, audio_write}, 32'h0);
        tick(1);
        check("wr2_same_edge_toggle_strobe", {31'h0, audio_write}, 32'h1);
        check("wr2_pre_toggle_sample", {8'h0, audio_left}, 32'h400000);
        check("wr2_level_toggled", {31'h0, wave_level}, 32'h0);
        tick(3);
        check("wr3_strobe", {31'h0, audio_write}, 32'h1);
        check("wr3_negative_sample", {8'h0, audio_right}, 32'hC00000);
        tick(12);

        // enable=0: writes continue with zero data.
        enable = 1'b0;
        tick(1);
        tick(3);
        wait_write("dis_write", 4);
        check("dis_left_zero", {8'h0, audio_left}, 32'h0);
        check("dis_right_zero", {8'h0, audio_right}, 32'h0);
        tick(6);

        // clk_count=0: muted, level forced high, samples zero.
        enable    = 1'b1;
        clk_count = 32'd0;
        tick(10);
        check("mute_level_high", {31'h0, wave_level}, 32'h1);
        wait_write("mute_write", 4);
        check("mute_left_zero", {8'h0, audio_left}, 32'h0);

        // Retune 4 -> 6 mid half-period from a muted start.
        audio_ready = 1'b0;
        tick(3);
        clk_count = 32'd4;
        tick(4);
        check("retune_pre_toggle", {31'h0, wave_level}, 32'h1);
        tick(2);
        check("retune_after_toggle", {31'h0, wave_level}, 32'h0);
        clk_count = 32'd6;
        tick(6);
        check("retune_no_early_toggle", {31'h0, wave_level}, 32'h0);
        tick(1);
        check("retune_toggle_at_6", {31'h0, wave_level}, 32'h1);
        tick(5);
        check("retune_hold_half", {31'h0, wave_level}, 32'h1);
        tick(1);
        check("retune_next_toggle", {31'h0, wave_level}, 32'h0);

        // Reset asserted mid-WRITE drops the strobe at once.
        audio_ready = 1'b1;
        wait_write("pre_reset_write", 6);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_drops_write", {31'h0, audio_write}, 32'h0);
        check("reset_clears_left", {8'h0, audio_left}, 32'h0);
        check("reset_sets_level", {31'h0, wave_level}, 32'h1);
        audio_ready = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check("post_reset_no_write", {31'h0, audio_write}, 32'h0);
        audio_ready = 1'b1;
        tick(1);
        check("post_reset_fresh_write", {31'h0, audio_write}, 32'h1);
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
